// File: rtl/vc_mem_copy_engine_pkg.sv
// Shared memory-message definitions and copy-engine state encoding.
// Message layouts (MSB first):
//   request : {type, opaque, addr, len, data}
//   response: {type, opaque, len, data}
package vc_mem_copy_engine_pkg;

    localparam int MEM_TYPE_NBITS = 3;

    typedef enum logic [MEM_TYPE_NBITS-1:0] {
        MEM_READ       = 3'd0,
        MEM_WRITE      = 3'd1,
        MEM_WRITE_INIT = 3'd2,
        MEM_AMO_ADD    = 3'd3,
        MEM_AMO_AND    = 3'd4,
        MEM_AMO_OR     = 3'd5
    } mem_type_e;

    // The len field encodes byte count within a word; zero means full word
    function automatic int mem_len_nbits(input int data_nbits);
        return $clog2(data_nbits / 8);
    endfunction

    function automatic int mem_req_nbits(input int opaque_nbits, input int addr_nbits,
                                         input int data_nbits);
        return MEM_TYPE_NBITS + opaque_nbits + addr_nbits + mem_len_nbits(data_nbits) + data_nbits;
    endfunction

    function automatic int mem_resp_nbits(input int opaque_nbits, input int data_nbits);
        return MEM_TYPE_NBITS + opaque_nbits + mem_len_nbits(data_nbits) + data_nbits;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/vc_mem_copy_engine_dpath.sv
// Copy-engine datapath: latched command, word index and tag counters,
// read-data buffer, response mismatch flag and address generation.
// Optional read-data checksum enabled by VC_MEM_COPY_CHECKSUM_EN.
module vc_mem_copy_engine_dpath
    import vc_mem_copy_engine_pkg::*;
#(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 16,
    parameter int p_data_nbits   = 32,
    parameter int p_count_nbits  = 16
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [p_addr_nbits-1:0]   go_src_addr,
    input  logic [p_addr_nbits-1:0]   go_dst_addr,
    input  logic [p_count_nbits-1:0]  go_nwords,
    input  logic                      rd_fire,
    input  logic                      wr_fire,
    input  logic [MEM_TYPE_NBITS-1:0] resp_type,
    input  logic [p_opaque_nbits-1:0] resp_opaque,
    input  logic [p_data_nbits-1:0]   resp_data,
    output logic [p_addr_nbits-1:0]   rd_addr,
    output logic [p_addr_nbits-1:0]   wr_addr,
    output logic [p_opaque_nbits-1:0] rd_tag,
    output logic [p_opaque_nbits-1:0] wr_tag,
    output logic [p_data_nbits-1:0]   buffer,
    output logic                      last_word,
`ifdef VC_MEM_COPY_CHECKSUM_EN
    output logic [p_data_nbits-1:0]   checksum,
`endif
    output logic                      err
);

    localparam int BYTE_SHIFT = $clog2(p_data_nbits / 8);

    logic [p_addr_nbits-1:0]   src_base;
    logic [p_addr_nbits-1:0]   dst_base;
    logic [p_count_nbits-1:0]  nwords;
    logic [p_count_nbits-1:0]  idx;
    logic [p_opaque_nbits-1:0] tag;

    // Word offsets are scaled to bytes; the add wraps silently at the address width
    assign rd_addr   = src_base + (p_addr_nbits'(idx) << BYTE_SHIFT);
    assign wr_addr   = dst_base + (p_addr_nbits'(idx) << BYTE_SHIFT);
    assign rd_tag    = tag;
    assign wr_tag    = tag + p_opaque_nbits'(1);
    assign last_word = (idx + p_count_nbits'(1)) == nwords;

    // Capture the copy command when it is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_base <= '0;
            dst_base <= '0;
            nwords   <= '0;
        end else if (load) begin
            src_base <= go_src_addr;
            dst_base <= go_dst_addr;
            nwords   <= go_nwords;
        end
    end

    // Advance word index and tag pair once each write completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
            tag <= '0;
        end else if (load) begin
            idx <= '0;
            tag <= '0;
        end else if (wr_fire) begin
            idx <= idx + p_count_nbits'(1);
            tag <= tag + p_opaque_nbits'(2);
        end
    end

    // Hold the most recent read data for the following write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buffer <= '0;
        end else if (rd_fire) begin
            buffer <= resp_data;
        end
    end

    // Sticky mismatch flag: wrong type or opaque on any response, cleared by a new command
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (load) begin
            err <= 1'b0;
        end else if (rd_fire && (resp_type != MEM_READ || resp_opaque != tag)) begin
            err <= 1'b1;
        end else if (wr_fire && (resp_type != MEM_WRITE || resp_opaque != wr_tag)) begin
            err <= 1'b1;
        end
    end

`ifdef VC_MEM_COPY_CHECKSUM_EN
    // Running modular sum of every word read during the current copy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (load) begin
            checksum <= '0;
        end else if (rd_fire) begin
            checksum <= checksum + resp_data;
        end
    end
`endif

endmodule

// File: rtl/vc_mem_copy_engine.sv
// Memory copy engine: accepts a copy command, then alternates one READ and
// one WRITE request per word with a single request outstanding.
// Optional done_checksum port enabled by VC_MEM_COPY_CHECKSUM_EN.
module vc_mem_copy_engine
    import vc_mem_copy_engine_pkg::*;
#(
    parameter  int p_opaque_nbits = 8,
    parameter  int p_addr_nbits   = 16,
    parameter  int p_data_nbits   = 32,
    parameter  int p_count_nbits  = 16,
    localparam int REQ_NBITS      = mem_req_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits),
    localparam int RESP_NBITS     = mem_resp_nbits(p_opaque_nbits, p_data_nbits)
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go_val,
    output logic                     go_rdy,
    input  logic [p_addr_nbits-1:0]  go_src_addr,
    input  logic [p_addr_nbits-1:0]  go_dst_addr,
    input  logic [p_count_nbits-1:0] go_nwords,
    output logic                     done_val,
    input  logic                     done_rdy,
    output logic                     done_err,
`ifdef VC_MEM_COPY_CHECKSUM_EN
    output logic [p_data_nbits-1:0]  done_checksum,
`endif
    output logic                     memreq_val,
    input  logic                     memreq_rdy,
    output logic [REQ_NBITS-1:0]     memreq_msg,
    input  logic                     memresp_val,
    output logic                     memresp_rdy,
    input  logic [RESP_NBITS-1:0]    memresp_msg
);

    localparam int LEN_NBITS = mem_len_nbits(p_data_nbits);

    state_e state;
    state_e state_next;

    logic                      load;
    logic                      rd_fire;
    logic                      wr_fire;
    logic [p_addr_nbits-1:0]   rd_addr;
    logic [p_addr_nbits-1:0]   wr_addr;
    logic [p_opaque_nbits-1:0] rd_tag;
    logic [p_opaque_nbits-1:0] wr_tag;
    logic [p_data_nbits-1:0]   buffer;
    logic                      last_word;
    logic                      err;

    logic [MEM_TYPE_NBITS-1:0] resp_type;
    logic [p_opaque_nbits-1:0] resp_opaque;
    logic [p_data_nbits-1:0]   resp_data;
    logic                      resp_len_unused;

    mem_type_e                 req_type;
    logic [p_opaque_nbits-1:0] req_opaque;
    logic [p_addr_nbits-1:0]   req_addr;
    logic [p_data_nbits-1:0]   req_data;

    assign resp_type       = memresp_msg[RESP_NBITS-1 -: MEM_TYPE_NBITS];
    assign resp_opaque     = memresp_msg[RESP_NBITS-MEM_TYPE_NBITS-1 -: p_opaque_nbits];
    assign resp_data       = memresp_msg[p_data_nbits-1:0];
    assign resp_len_unused = ^memresp_msg[p_data_nbits +: LEN_NBITS];

    assign memreq_msg = {req_type, req_opaque, req_addr, {LEN_NBITS{1'b0}}, req_data};

    assign load     = go_val && (state == ST_IDLE);
    assign rd_fire  = memresp_val && (state == ST_RD_WAIT);
    assign wr_fire  = memresp_val && (state == ST_WR_WAIT);
    assign done_err = done_val && err;

    vc_mem_copy_engine_dpath #(
        .p_opaque_nbits (p_opaque_nbits),
        .p_addr_nbits   (p_addr_nbits),
        .p_data_nbits   (p_data_nbits),
        .p_count_nbits  (p_count_nbits)
    ) dpath (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .go_src_addr (go_src_addr),
        .go_dst_addr (go_dst_addr),
        .go_nwords   (go_nwords),
        .rd_fire     (rd_fire),
        .wr_fire     (wr_fire),
        .resp_type   (resp_type),
        .resp_opaque (resp_opaque),
        .resp_data   (resp_data),
        .rd_addr     (rd_addr),
        .wr_addr     (wr_addr),
        .rd_tag      (rd_tag),
        .wr_tag      (wr_tag),
        .buffer      (buffer),
        .last_word   (last_word),
`ifdef VC_MEM_COPY_CHECKSUM_EN
        .checksum    (done_checksum),
`endif
        .err         (err)
    );

    // State register; reset aborts any copy in progress immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; request fields depend only on state so they hold during stalls
    always_comb begin
        state_next  = state;
        go_rdy      = 1'b0;
        done_val    = 1'b0;
        memreq_val  = 1'b0;
        memresp_rdy = 1'b0;
        req_type    = MEM_READ;
        req_opaque  = rd_tag;
        req_addr    = rd_addr;
        req_data    = '0;
        case (state)
            ST_IDLE: begin
                go_rdy = 1'b1;
                if (go_val) begin
                    state_next = (go_nwords == '0) ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                memreq_val = 1'b1;
                if (memreq_rdy) begin
                    state_next = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                memresp_rdy = 1'b1;
                if (memresp_val) begin
                    state_next = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                memreq_val = 1'b1;
                req_type   = MEM_WRITE;
                req_opaque = wr_tag;
                req_addr   = wr_addr;
                req_data   = buffer;
                if (memreq_rdy) begin
                    state_next = ST_WR_WAIT;
                end
            end
            ST_WR_WAIT: begin
                memresp_rdy = 1'b1;
                if (memresp_val) begin
                    state_next = last_word ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_DONE: begin
                done_val = 1'b1;
                if (done_rdy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
